// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - frame parser constants, state encoding and CRC16 step
package frame_pkg;

  localparam logic [15:0] HEADER_WORD  = 16'hE0E0;
  localparam logic [15:0] TRAILER_WORD = 16'h0E0E;
  localparam int          MAX_WORDS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_CHAN  = 3'd2,
    ST_PAYLD = 3'd3,
    ST_TRL   = 3'd4
  } parser_state_t;

  // CCITT x^16+x^12+x^5+1, MSB first; unrolls to the parallel 16-bit equations
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_parser_if.sv
// rtl/frame_parser_if.sv - frame record write port toward the clock-crossing FIFO
interface frame_parser_if;
  logic         fifo_full;
  logic         frame_vld;
  logic [7:0]   frame_chan;
  logic [3:0]   frame_len;
  logic [127:0] frame_data;

  modport master (
    input  fifo_full,
    output frame_vld, frame_chan, frame_len, frame_data
  );

  modport slave (
    output fifo_full,
    input  frame_vld, frame_chan, frame_len, frame_data
  );
endinterface

// File: rtl/frame_parser.sv
// rtl/frame_parser.sv - header/channel/payload/CRC/trailer parser emitting frame records
module frame_parser
  import frame_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst,
  input  logic [15:0]   data_in,
  frame_parser_if.master fifo_wr,
  output logic          crc_err,
  output logic          fmt_err,
  output logic          drop
);

  localparam logic [3:0] MAX_PUSH = 4'(MAX_WORDS + 1);

  parser_state_t state_q;
  logic [7:0]    chan_q;
  logic [143:0]  buf_q;
  logic [3:0]    count_q;
  logic [15:0]   crc_cur_q;
  logic [15:0]   crc_prev_q;

  logic [15:0] crc_one;
  logic [15:0] crc_held;
  logic [15:0] crc_two;
  logic        chan_ok;
  logic        is_hdr;
  logic        is_trl;

  always_comb begin
    is_hdr   = (data_in == HEADER_WORD);
    is_trl   = (data_in == TRAILER_WORD);
    chan_ok  = (data_in[15:8] == 8'h00) && (data_in[7:0] != 8'h00) &&
               ((data_in[7:0] & (data_in[7:0] - 8'd1)) == 8'h00);
    crc_one  = crc16_step(crc_cur_q, data_in);
    // Held trailer word plus a non-trailer word: two chained steps in one cycle
    crc_held = crc16_step(crc_cur_q, TRAILER_WORD);
    crc_two  = crc16_step(crc_held, data_in);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      chan_q             <= 8'h00;
      buf_q              <= '0;
      count_q            <= 4'd0;
      crc_cur_q          <= 16'h0000;
      crc_prev_q         <= 16'h0000;
      fifo_wr.frame_vld  <= 1'b0;
      fifo_wr.frame_chan <= 8'h00;
      fifo_wr.frame_len  <= 4'd0;
      fifo_wr.frame_data <= '0;
      crc_err            <= 1'b0;
      fmt_err            <= 1'b0;
      drop               <= 1'b0;
    end else begin
      fifo_wr.frame_vld <= 1'b0;
      crc_err           <= 1'b0;
      fmt_err           <= 1'b0;
      drop              <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (is_hdr) state_q <= ST_HDR;
        end
        ST_HDR: begin
          state_q <= is_hdr ? ST_CHAN : ST_IDLE;
        end
        ST_CHAN: begin
          if (chan_ok) begin
            chan_q     <= data_in[7:0];
            count_q    <= 4'd0;
            crc_cur_q  <= 16'h0000;
            crc_prev_q <= 16'h0000;
            buf_q      <= '0;
            state_q    <= ST_PAYLD;
          end else if (!is_hdr) begin
            fmt_err <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_PAYLD: begin
          if (is_trl) begin
            state_q <= ST_TRL;
          end else if (count_q >= MAX_PUSH) begin
            fmt_err <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            buf_q      <= {buf_q[127:0], data_in};
            count_q    <= count_q + 4'd1;
            crc_prev_q <= crc_cur_q;
            crc_cur_q  <= crc_one;
          end
        end
        ST_TRL: begin
          if (is_trl) begin
            state_q <= ST_IDLE;
            // Last pushed word is the received CRC; crc_prev covers the payload before it
            if (count_q < 4'd2) begin
              fmt_err <= 1'b1;
            end else if (crc_prev_q != buf_q[15:0]) begin
              crc_err <= 1'b1;
            end else if (fifo_wr.fifo_full) begin
              drop <= 1'b1;
            end else begin
              fifo_wr.frame_vld  <= 1'b1;
              fifo_wr.frame_chan <= chan_q;
              fifo_wr.frame_len  <= count_q - 4'd1;
              fifo_wr.frame_data <= buf_q[143:16];
            end
          end else if (count_q >= MAX_PUSH - 4'd1) begin
            fmt_err <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            buf_q      <= {buf_q[111:0], TRAILER_WORD, data_in};
            count_q    <= count_q + 4'd2;
            crc_prev_q <= crc_held;
            crc_cur_q  <= crc_two;
            state_q    <= ST_PAYLD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_parser.md
Name: frame_parser

Overview:
- Input-side frame parser in the clk_in domain; consumes the raw 16-bit big-endian word stream data_in.
- Detects header E0E0_E0E0 and captures the one-hot channel word.
- Collects 1–8 payload words, then the CRC word, then trailer 0E0E_0E0E, and checks CRC16.
- Emits one packed frame record per good frame to the write side of the clock-crossing FIFO that feeds the gray-code/serializer channels.

Parameters:
- HEADER_WORD, 16'hE0E0, header half-word; the header is two consecutive HEADER_WORDs.
- TRAILER_WORD, 16'h0E0E, trailer half-word; the trailer is two consecutive TRAILER_WORDs.
- MAX_WORDS, 8, maximum payload words (128 bits).

Ports:
- clk_in  in  1  input word clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  16  input word, sampled every clk_in rising edge.
- fifo_full  in  1  downstream FIFO full.
- frame_vld  out  1  one-cycle write strobe for the frame record.
- frame_chan  out  8  one-hot channel of the emitted frame.
- frame_len  out  4  payload word count, 1..8.
- frame_data  out  128  payload, right-aligned; first received word is the most significant.
- crc_err  out  1  one-cycle pulse when a frame fails CRC.
- fmt_err  out  1  one-cycle pulse for a bad channel word or overlength payload.
- drop  out  1  one-cycle pulse when a good frame is discarded because fifo_full=1.

Behaviour:
- Reset: all outputs 0; state IDLE; word buffer, count and CRC registers cleared.
- Reset asserted mid-frame aborts the frame silently, with no error pulse.
- States: IDLE, HDR, CHAN, PAYLD, TRL.
- IDLE: data_in==HEADER_WORD -> HDR.
- HDR:
  - HEADER_WORD -> CHAN.
  - Any other word -> IDLE.
- CHAN: the valid channel word is data_in[15:8]==0 and data_in[7:0] one-hot.
  - Valid word: latch the channel, clear count and CRC -> PAYLD.
  - data_in==HEADER_WORD: stay in CHAN, to realign on a run of header words.
  - Anything else: pulse fmt_err -> IDLE.
- PAYLD:
  - data_in==TRAILER_WORD -> TRL, holding the word tentatively; it is not pushed.
  - Else push the word: shift it into the buffer, count++, crc_prev<=crc_cur, crc_cur<=crc16_step(crc_cur,word).
- TRL:
  - data_in==TRAILER_WORD: end of frame. The last pushed word is the received CRC, and data is the count-1 words before it.
  - Else: push the held TRAILER_WORD as data, then treat data_in as in PAYLD. Pushing both the held word and a non-trailer word costs two CRC steps in one cycle; chain the combinational step twice.
- Overlength: if a push would make count exceed MAX_WORDS+1, pulse fmt_err -> IDLE.
- End-of-frame checks, evaluated in order:
  1. count<2 (no payload): fmt_err.
  2. crc_prev != last pushed word: crc_err.
  3. fifo_full=1: drop.
  4. Otherwise frame_vld=1.
- End-of-frame timing and state:
  - The selected pulse asserts in the cycle after the second trailer word is sampled (one registered cycle).
  - frame_data, frame_len and frame_chan are valid while frame_vld=1 and held until the next frame.
  - The state returns to IDLE.
- CRC definition:
  - Polynomial x^16+x^12+x^5+1, init 0x0000, MSB-first, no reflection, no final XOR.
  - Computed 16 bits per step over the payload words only.
  - Because the init is 0, this equals the CRC over the zero-extended 128-bit value.
- Packing: frame_data = buffer right-aligned over the count-1 payload words; upper unused bits are 0.
- Back-to-back frames: a header may start in the cycle immediately after the second trailer word, because IDLE is entered on that edge.
- Protocol limitation, by design: a payload or CRC word equal to 0E0E followed by 0E0E ends the frame early. Such a frame normally fails CRC and is reported as crc_err.

Decomposition:
- Package frame_pkg:
  - HEADER_WORD, TRAILER_WORD, MAX_WORDS.
  - State enum parser_state_t.
  - Function crc16_step(crc[15:0], d[15:0]): the parallel 16-bit CCITT equations, shared with the bench model.
- No separate sub-module: the parser FSM, 9x16 shift buffer and CRC registers all live in frame_parser.

Test Plan:
- Good short frame: ch=8'h01, payload A55A, correct CRC from crc16_step -> frame_vld once, frame_len=1, frame_data=128'hA55A, frame_chan=8'h01, no error pulses.
- Good max frame: ch=8'h02, payload 0123456789ABCDEFFEDCBA9876543210, 8 words, correct CRC -> frame_vld, frame_len=8, frame_data matches exactly.
- Bad CRC: ch=8'h01, payload 1234, CRC FFFF -> crc_err pulse, frame_vld stays 0.
- Embedded 0E0E: payload {0E0E,1111} with correct CRC -> frame_len=2, frame_data=128'h0E0E_1111, frame_vld.
- Format and overlength errors:
  - Channel word 16'h0003 -> fmt_err, no frame.
  - 10 words before trailer -> fmt_err, parser back in IDLE.
  - A following good frame is accepted.
- Full FIFO and reset:
  - fifo_full=1 at the end of a good frame -> drop pulse, no frame_vld.
  - rst asserted after the 3rd payload word, then a fresh good frame -> only the second frame emitted.
  - Two good frames back-to-back with no idle gap -> two frame_vld pulses.
